// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared constants for the single-MAC filter datapath
package filter_pkg;

  // sample and coefficient geometry shared with singleMaccFilter
  localparam int DATA_W       = 18;
  localparam int TAPS         = 16;
  localparam int COEFF_ADDR_W = 4;
  localparam int COEFF_W      = 18;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - single-clock sample FIFO with combinational head read
module sample_fifo #(
  parameter int DW    = filter_pkg::DATA_W,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  import filter_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_wr, do_rd;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // pointer and occupancy update; writes when full and reads when empty are ignored
  always_comb begin
    do_wr    = wr & ~full;
    do_rd    = rd & ~empty;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (do_wr & ~do_rd) begin
      level_d = level_q + (AW+1)'(1);
    end else if (do_rd & ~do_wr) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // pointers and level, cleared asynchronously so stale contents become unreachable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // sample storage needs no reset: it is only read behind a valid level
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/filter_sample_pacer.sv
// rtl/filter_sample_pacer.sv - buffers bursty samples and paces DataNd strobes to the filter
module filter_sample_pacer #(
  parameter int DATA_W  = filter_pkg::DATA_W,
  parameter int DEPTH   = 16,
  parameter int SPACING = filter_pkg::TAPS
) (
  input  logic                   Clk_i,
  input  logic                   RstN_i,
  input  logic [DATA_W-1:0]      Data_i,
  input  logic                   DataValid_i,
  output logic                   DataReady_o,
  input  logic                   ClrOvf_i,
  output logic [DATA_W-1:0]      Data_o,
  output logic                   DataNd_o,
  output logic [$clog2(DEPTH):0] Level_o,
  output logic                   Overflow_o
);

  import filter_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int GW = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(SPACING - 1);

  logic              ready_q, ready_d;
  logic              ovf_q, ovf_d;
  logic              nd_q, nd_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] head;
  logic [LW-1:0]     level;
  logic              full, empty, wr, emit;

  sample_fifo #(
    .DW    (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk_i),
    .rst_n (RstN_i),
    .wr    (wr),
    .rd    (emit),
    .din   (Data_i),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign DataReady_o = ready_q & ~full;
  assign wr          = DataValid_i & DataReady_o;
  assign emit        = ~empty & (gap_q == '0);
  assign Data_o      = data_q;
  assign DataNd_o    = nd_q;
  assign Level_o     = level;
  assign Overflow_o  = ovf_q;

  // next state: sticky overflow (set beats clear), spacing countdown, output capture
  always_comb begin
    ready_d = 1'b1;
    ovf_d   = ovf_q;
    if (DataValid_i & full) begin
      ovf_d = 1'b1;
    end else if (ClrOvf_i) begin
      ovf_d = 1'b0;
    end
    gap_d = gap_q;
    if (emit) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
    nd_d   = emit;
    data_d = emit ? head : data_q;
  end

  // control and output registers; reset cancels any strobe in flight at once
  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      nd_q    <= 1'b0;
      gap_q   <= '0;
      data_q  <= '0;
    end else begin
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      nd_q    <= nd_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_filter_sample_pacer.sv
// tb/tb_filter_sample_pacer.sv - self-checking bench for filter_sample_pacer
`timescale 1ns/1ps
module tb_filter_sample_pacer;

  localparam int DW      = 18;
  localparam int DEPTH   = 16;
  localparam int SPACING = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din   = '0;
  logic          valid = 1'b0;
  logic          clr   = 1'b0;
  logic          ready, nd, ovf;
  logic [DW-1:0] dout;
  logic [4:0]    level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // behavioural model: a queue of samples plus the earliest cycle the next strobe may fire
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data = '0;
  logic          m_nd   = 1'b0;
  logic          m_ovf  = 1'b0;
  logic          m_rdy  = 1'b0;
  int            m_cyc  = 0;
  int            m_next = 0;

  int strb_edge[$];
  logic [DW-1:0] strb_data[$];

  filter_sample_pacer #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .SPACING (SPACING)
  ) dut (
    .Clk_i       (clk),
    .RstN_i      (rst_n),
    .Data_i      (din),
    .DataValid_i (valid),
    .DataReady_o (ready),
    .ClrOvf_i    (clr),
    .Data_o      (dout),
    .DataNd_o    (nd),
    .Level_o     (level),
    .Overflow_o  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_emit_next();
    return (m_q.size() > 0) && (m_cyc >= m_next);
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_strobes();
    strb_edge.delete();
    strb_data.delete();
  endtask

  // model update on every active edge, cleared by the asynchronous reset
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_data = '0;
      m_nd   = 1'b0;
      m_ovf  = 1'b0;
      m_rdy  = 1'b0;
      m_next = m_cyc;
    end else begin
      automatic int  lvl    = m_q.size();
      automatic bit  isfull = (lvl == DEPTH);
      automatic bit  acc    = valid && m_rdy && !isfull;
      if (lvl > 0 && m_cyc >= m_next) begin
        m_data = m_q.pop_front();
        m_nd   = 1'b1;
        m_next = m_cyc + SPACING;
      end else begin
        m_nd = 1'b0;
      end
      if (acc) m_q.push_back(din);
      if (valid && isfull) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_rdy = 1'b1;
      m_cyc++;
    end
  end

  // compare every output against the model on each falling edge and log strobes
  initial forever begin
    @(negedge clk);
    check("data_o", 32'(dout), 32'(m_data));
    check("datand_o", 32'(nd), 32'(m_nd));
    check("level_o", 32'(level), 32'(m_q.size()));
    check("overflow_o", 32'(ovf), 32'(m_ovf));
    check("dataready_o", 32'(ready), 32'(m_rdy && (m_q.size() != DEPTH)));
    if (nd === 1'b1) begin
      strb_edge.push_back(cyc + 1);
      strb_data.push_back(dout);
    end
  end

  initial begin
    int wr_edge, idx, peak, pin_cnt, prev_level, k;
    bit hs, hs_prev, saw_low, pinned;

    // reset state
    wait_neg(3);
    check("rst_data", 32'(dout), 32'd0);
    check("rst_nd", 32'(nd), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    wait_neg(1);
    check("ready_after_release", 32'(ready), 32'd1);

    // single sample into an empty pacer
    clear_strobes();
    valid = 1'b1; din = 18'h1FFFF; wr_edge = cyc + 1;
    wait_neg(1);
    valid = 1'b0;
    check("t1_level_after_write", 32'(level), 32'd1);
    check("t1_no_strobe_yet", 32'(nd), 32'd0);
    wait_neg(1);
    check("t1_strobe", 32'(nd), 32'd1);
    check("t1_data", 32'(dout), 32'h1FFFF);
    wait_neg(40); #1;
    check("t1_strobe_count", 32'(strb_edge.size()), 32'd1);
    if (strb_edge.size() >= 1) check("t1_latency", 32'(strb_edge[0] - wr_edge), 32'd2);

    // burst of four back-to-back samples
    clear_strobes();
    peak = 0;
    for (int i = 1; i <= 4; i++) begin
      valid = 1'b1; din = DW'(i);
      wait_neg(1);
      if (int'(level) > peak) peak = int'(level);
    end
    valid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      wait_neg(1);
      if (int'(level) > peak) peak = int'(level);
    end
    #1;
    check("t2_strobe_count", 32'(strb_edge.size()), 32'd4);
    for (int i = 0; i < 4 && i < strb_edge.size(); i++) begin
      check($sformatf("t2_data%0d", i), 32'(strb_data[i]), 32'(i + 1));
      if (i > 0) check($sformatf("t2_gap%0d", i), 32'(strb_edge[i] - strb_edge[i-1]), 32'd16);
    end
    check("t2_peak_level", 32'(peak), 32'd3);
    check("t2_final_level", 32'(level), 32'd0);

    // twenty samples from a source that honours ready
    idx = 0; saw_low = 1'b0;
    for (k = 0; k < 400 && idx < 20; k++) begin
      if (!ready && !saw_low) begin
        saw_low = 1'b1;
        check("t3_ready_low_at_full", 32'(level), 32'd16);
      end
      valid = ready; din = DW'(32'h100 + idx);
      if (valid) idx++;
      wait_neg(1);
    end
    valid = 1'b0;
    check("t3_all_sent", 32'(idx), 32'd20);
    check("t3_ready_fell", 32'(saw_low), 32'd1);
    check("t3_no_overflow", 32'(ovf), 32'd0);

    // overflow set, sticky, cleared, and set winning over clear
    for (k = 0; k < 100 && level != 5'd16; k++) begin
      valid = ready; din = DW'(32'h150 + k);
      wait_neg(1);
    end
    check("t4_reached_full", 32'(level), 32'd16);
    valid = 1'b1; din = 18'h3AAAA;
    wait_neg(1);
    valid = 1'b0;
    check("t4_ovf_set", 32'(ovf), 32'd1);
    wait_neg(3);
    check("t4_ovf_sticky", 32'(ovf), 32'd1);
    clr = 1'b1;
    wait_neg(1);
    clr = 1'b0;
    check("t4_ovf_cleared", 32'(ovf), 32'd0);
    for (k = 0; k < 100 && level != 5'd16; k++) begin
      valid = ready; din = DW'(32'h180 + k);
      wait_neg(1);
    end
    check("t4_refull", 32'(level), 32'd16);
    valid = 1'b1; clr = 1'b1; din = 18'h15555;
    wait_neg(1);
    valid = 1'b0; clr = 1'b0;
    check("t4_set_beats_clear", 32'(ovf), 32'd1);

    // drain, then write and emit together at level fifteen
    for (k = 0; k < 400 && level != 5'd0; k++) wait_neg(1);
    check("t5_drained", 32'(level), 32'd0);
    wait_neg(20); #1;
    clear_strobes();
    idx = 0; pin_cnt = 0; hs_prev = 1'b0; prev_level = 0;
    for (k = 0; k < 600 && (idx < 20 || hs_prev); k++) begin
      if (hs_prev && prev_level == 15 && nd) begin
        check("t5_level_hold", 32'(level), 32'd15);
        pin_cnt++;
      end
      hs = (idx < 20) && ready && !(level == 5'd15 && !m_emit_next());
      valid = hs; din = DW'(32'h200 + idx);
      prev_level = int'(level);
      hs_prev = hs;
      if (hs) idx++;
      wait_neg(1);
    end
    valid = 1'b0;
    wait_neg(300); #1;
    check("t5_pin_seen", 32'(pin_cnt > 0), 32'd1);
    check("t5_strobe_count", 32'(strb_edge.size()), 32'd20);
    for (int i = 0; i < 20 && i < strb_data.size(); i++)
      check($sformatf("t5_order%0d", i), 32'(strb_data[i]), 32'h200 + i);

    // reset mid-burst between strobes
    idx = 0; pinned = 1'b0;
    for (k = 0; k < 100; k++) begin
      if (level == 5'd5 && !nd) begin
        pinned = 1'b1;
        break;
      end
      valid = ready; din = DW'(32'h300 + idx);
      if (valid) idx++;
      wait_neg(1);
    end
    valid = 1'b0;
    check("t6_reached_level5", 32'(pinned), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_data", 32'(dout), 32'd0);
    check("t6_rst_nd", 32'(nd), 32'd0);
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_ovf", 32'(ovf), 32'd0);
    check("t6_rst_ready", 32'(ready), 32'd0);
    wait_neg(2);
    rst_n = 1'b1;
    clear_strobes();
    wait_neg(30); #1;
    check("t6_no_stale", 32'(strb_edge.size()), 32'd0);
    wait_neg(1);
    valid = 1'b1; din = 18'h2BEEF; wr_edge = cyc + 1;
    wait_neg(1);
    valid = 1'b0;
    wait_neg(3); #1;
    check("t6_strobe_count", 32'(strb_edge.size()), 32'd1);
    if (strb_edge.size() >= 1) begin
      check("t6_data", 32'(strb_data[0]), 32'h2BEEF);
      check("t6_latency", 32'(strb_edge[0] - wr_edge), 32'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
